// File: rtl/mem_req_ctrl_pkg.sv
// Shared sizes and the response entry layout for the data-memory request controller.
// MEM_DEPTH lives here so the memory and the controller agree on the valid address range.
package mem_req_ctrl_pkg;

  localparam int HBIT_ADDR     = 12;
  localparam int HBIT_DATA     = 31;
  localparam int DEF_MEM_DEPTH = 4096;
  localparam int DEF_RSP_DEPTH = 4;

  typedef struct packed {
    logic [HBIT_DATA:0] rdata;
    logic               err;
  } rsp_entry_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// Synchronous response FIFO; power-of-two depth so pointers wrap naturally.
// The head reads as zero when empty so all outputs are quiet out of reset.
module mem_rsp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] store [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_data;
  end

  assign empty    = (count == '0);
  assign pop_data = empty ? '0 : store[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == ($clog2(DEPTH)+1)'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && empty));

endmodule

// File: rtl/mem_req_ctrl.sv
// Initiator-side controller for the single-port synchronous data memory: registered
// issue stage, two-stage read tracking, and a credit-protected in-order response FIFO.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic                iw_clk,
  input  logic                iw_rst_n,
  input  logic                iw_req_valid,
  output logic                or_req_ready,
  input  logic                iw_req_we,
  input  logic [HBIT_ADDR:0]  iw_req_addr,
  input  logic [HBIT_DATA:0]  iw_req_wdata,
  output logic                or_mem_we,
  output logic [HBIT_ADDR:0]  or_mem_addr,
  output logic [HBIT_DATA:0]  or_mem_wdata,
  input  logic [HBIT_DATA:0]  iw_mem_rdata,
  output logic                or_rsp_valid,
  input  logic                iw_rsp_ready,
  output logic [HBIT_DATA:0]  or_rsp_rdata,
  output logic                or_rsp_err
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam logic [HBIT_ADDR+1:0] MEM_LIMIT = (HBIT_ADDR+2)'(MEM_DEPTH);

  logic          run;
  logic [CW-1:0] credits_used;
  logic          in_range;
  logic          accept;
  logic          rsp_fire;
  logic          issue_rd;
  logic          issue_err;
  logic          cap_rd;
  logic          cap_err;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  rsp_entry_t    push_entry;
  rsp_entry_t    head;

  assign in_range     = ({1'b0, iw_req_addr} < MEM_LIMIT);
  // run keeps ready low during reset and lifts it on the first edge after release
  assign or_req_ready = run && (credits_used < CW'(RSP_DEPTH));
  assign accept       = iw_req_valid && or_req_ready;
  assign rsp_fire     = or_rsp_valid && iw_rsp_ready;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) run <= 1'b0;
    else           run <= 1'b1;
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      or_mem_we    <= 1'b0;
      or_mem_addr  <= '0;
      or_mem_wdata <= '0;
      issue_rd     <= 1'b0;
      issue_err    <= 1'b0;
      cap_rd       <= 1'b0;
      cap_err      <= 1'b0;
    end else begin
      or_mem_we <= accept && iw_req_we && in_range;
      if (accept) begin
        or_mem_addr  <= iw_req_addr;
        or_mem_wdata <= iw_req_wdata;
      end
      issue_rd  <= accept && !iw_req_we;
      issue_err <= accept && !iw_req_we && !in_range;
      cap_rd    <= issue_rd;
      cap_err   <= issue_err;
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      credits_used <= '0;
    end else begin
      case ({accept && !iw_req_we, rsp_fire})
        2'b10:   credits_used <= credits_used + 1'b1;
        2'b01:   credits_used <= credits_used - 1'b1;
        default: credits_used <= credits_used;
      endcase
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.rdata = cap_err ? '0 : iw_mem_rdata;
    push_entry.err   = cap_err;
  end

  mem_rsp_fifo #(
    .WIDTH ($bits(rsp_entry_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (iw_clk),
    .rst_n     (iw_rst_n),
    .push      (cap_rd),
    .push_data (push_entry),
    .pop       (rsp_fire),
    .pop_data  (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign or_rsp_valid = !fifo_empty;
  assign or_rsp_rdata = head.rdata;
  assign or_rsp_err   = head.err;

  a_credit_covers_fifo: assert property (@(posedge iw_clk) disable iff (!iw_rst_n)
    fifo_count <= credits_used);

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Randomized bench for mem_req_ctrl: a word-array memory environment plus a
// reference model of architectural memory contents and an expected-response queue.
module tb_mem_req_ctrl;

  localparam int MEMD = 4096;
  localparam int RSPD = 4;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] env_mem [MEMD];
  logic        env_init = 1'b0;
  logic [31:0] ref_mem [MEMD];
  exp_t        exp_q[$];
  int          outstanding = 0;
  logic        exp_we = 1'b0;

  mem_req_ctrl #(.MEM_DEPTH(MEMD), .RSP_DEPTH(RSPD)) dut (
    .iw_clk       (clk),
    .iw_rst_n     (rst_n),
    .iw_req_valid (req_valid),
    .or_req_ready (req_ready),
    .iw_req_we    (req_we),
    .iw_req_addr  (req_addr),
    .iw_req_wdata (req_wdata),
    .or_mem_we    (mem_we),
    .or_mem_addr  (mem_addr),
    .or_mem_wdata (mem_wdata),
    .iw_mem_rdata (mem_rdata),
    .or_rsp_valid (rsp_valid),
    .iw_rsp_ready (rsp_ready),
    .or_rsp_rdata (rsp_rdata),
    .or_rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // Memory environment: low address bits alias, so a stray out-of-range write would corrupt word 0.
  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < MEMD; i++) env_mem[i] <= 32'(i);
      env_init <= 1'b1;
    end else if (mem_we) begin
      env_mem[mem_addr[11:0]] <= mem_wdata;
    end
    mem_rdata <= (mem_addr < 13'(MEMD)) ? env_mem[mem_addr[11:0]] : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Drive one cycle at a negedge, predict the handshakes of the coming edge, then check.
  task automatic tick(input logic v, input logic we, input logic [12:0] a,
                      input logic [31:0] d, input logic rr);
    logic        acc;
    logic        pop;
    logic        hold;
    logic [31:0] hold_d;
    logic        hold_e;
    logic        inr;
    exp_t        e;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr;
    inr    = (a < 13'(MEMD));
    acc    = v && req_ready;
    pop    = rsp_valid && rr;
    hold   = rsp_valid && !rr;
    hold_d = rsp_rdata;
    hold_e = rsp_err;
    if (pop) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", rsp_rdata, e.data);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
      outstanding--;
    end
    exp_we = 1'b0;
    if (acc) begin
      if (we) begin
        if (inr) ref_mem[a[11:0]] = d;
        exp_we = inr;
      end else begin
        e.data = inr ? ref_mem[a[11:0]] : 32'h0;
        e.err  = !inr;
        exp_q.push_back(e);
        outstanding++;
      end
    end
    @(negedge clk);
    check("mem_we", 32'(mem_we), 32'(exp_we));
    if (acc) begin
      check("mem_addr", 32'(mem_addr), 32'(a));
      check("mem_wdata", mem_wdata, d);
    end
    check("req_ready", 32'(req_ready), 32'(outstanding < RSPD));
    if (hold) begin
      check("hold_valid", 32'(rsp_valid), 32'(1));
      check("hold_data", rsp_rdata, hold_d);
      check("hold_err", 32'(rsp_err), 32'(hold_e));
    end
  endtask

  task automatic idle(input logic rr);
    tick(1'b0, 1'b0, 13'h0, 32'h0, rr);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (exp_q.size() != 0 || rsp_valid); i++) idle(1'b1);
    check("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    logic        v, we, rr;
    logic [12:0] a;
    int unsigned r;
    for (int i = 0; i < MEMD; i++) ref_mem[i] = 32'(i);
    rst_n = 1'b0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
    @(negedge clk); @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    rst_n = 1'b1;
    idle(1'b0);

    // Store then load to the same address; response two edges after the load accept.
    tick(1'b1, 1'b1, 13'h010, 32'h0000_A5A5, 1'b0);
    tick(1'b1, 1'b0, 13'h010, 32'h0, 1'b0);
    check("lat_k0_valid", 32'(rsp_valid), 32'(0));
    idle(1'b0);
    check("lat_k1_valid", 32'(rsp_valid), 32'(0));
    idle(1'b0);
    check("lat_k2_valid", 32'(rsp_valid), 32'(1));
    check("lat_k2_data", rsp_rdata, 32'h0000_A5A5);
    check("lat_k2_err", 32'(rsp_err), 32'(0));
    drain();

    // Four loads under backpressure fill the credits.
    for (int i = 1; i <= 4; i++) tick(1'b1, 1'b0, 13'(i), 32'h0, 1'b0);
    check("full_ready", 32'(req_ready), 32'(0));
    idle(1'b0); idle(1'b0); idle(1'b0);
    idle(1'b1);
    check("ready_after_pop", 32'(req_ready), 32'(1));
    drain();

    // Out-of-range load and store; word 0 must stay untouched.
    tick(1'b1, 1'b0, 13'h1000, 32'h0, 1'b1);
    tick(1'b1, 1'b1, 13'h1000, 32'h1234_5678, 1'b1);
    tick(1'b1, 1'b0, 13'h0000, 32'h0, 1'b1);
    drain();

    // Steady stream with the response side always ready.
    for (int i = 0; i < 24; i++) begin
      tick(1'b1, 1'b0, 13'(i % 32), 32'h0, 1'b1);
      check("stream_ready", 32'(req_ready), 32'(1));
      if (i >= 2) check("stream_valid", 32'(rsp_valid), 32'(1));
    end
    drain();

    for (int n = 0; n < 12000; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1) == 1;
      rr = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 15);
      if (r == 0)      a = 13'($urandom_range(4096, 8191));
      else if (r == 1) a = 13'(4095);
      else             a = 13'($urandom_range(0, 31));
      tick(v, we, a, $urandom, rr);
    end
    drain();

    // Reset in the middle of buffered loads.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 13'(i), 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(req_ready), 32'(0));
    check("arst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("arst_rsp_data", rsp_rdata, 32'h0);
    check("arst_rsp_err", 32'(rsp_err), 32'(0));
    check("arst_mem_we", 32'(mem_we), 32'(0));
    check("arst_mem_addr", 32'(mem_addr), 32'(0));
    check("arst_mem_wdata", mem_wdata, 32'h0);
    exp_q.delete();
    outstanding = 0;
    req_valid = 0; rsp_ready = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    check("post_rst_ready", 32'(req_ready), 32'(1));
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      check("no_stale_rsp", 32'(rsp_valid), 32'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
